dot_mac_engine: RTL

- Downstream consumer of the 16-bit operand RAMs, ramA and ramB.
- On a start pulse it sweeps a shared address over len entries of both RAMs and multiplies each signed 16-bit pair.
- It accumulates the products and presents one signed dot-product result with a done pulse.
- It sits between the operand RAMs and the result store/controller in the non-pipelined datapath.

---
 rtl/dot_mac_pkg.sv | 19 +
 rtl/dot_mac_fit.sv | 31 +++
 rtl/dot_mac_engine.sv | 103 ++++++++++
 3 files changed

// File: rtl/dot_mac_pkg.sv
// dot_mac_pkg: shared widths, FSM state encodings and result saturation
// limits for the dot-product MAC engine.
package dot_mac_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int ACC_W  = 2*DATA_W + ADDR_W;
  localparam int RES_W  = 2*DATA_W;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t FLUSH = 2'd2;

  localparam logic [RES_W-1:0] RES_SAT_MAX = {1'b0, {(RES_W-1){1'b1}}};
  localparam logic [RES_W-1:0] RES_SAT_MIN = {1'b1, {(RES_W-1){1'b0}}};

endpackage

// File: rtl/dot_mac_fit.sv
// dot_mac_fit: narrows the wide signed accumulator to the result width.
// Default build wraps (keeps the low RES_W bits); defining DOT_MAC_SAT_EN
// clamps to the signed RES_W range instead.
module dot_mac_fit
  import dot_mac_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output logic        [RES_W-1:0] res
);

`ifdef DOT_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-RES_W){1'b0}}, RES_SAT_MAX};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-RES_W){1'b1}}, RES_SAT_MIN};

  // Clamp out-of-range sums to the nearest representable result.
  always_comb begin
    res = acc[RES_W-1:0];
    if (acc > ACC_MAX) begin
      res = RES_SAT_MAX;
    end else if (acc < ACC_MIN) begin
      res = RES_SAT_MIN;
    end
  end
`else
  logic unused_upper;

  assign unused_upper = ^acc[ACC_W-1:RES_W];
  assign res          = acc[RES_W-1:0];
`endif

endmodule

// File: rtl/dot_mac_engine.sv
// dot_mac_engine: sweeps a shared address over len entries of ramA/ramB,
// multiplies each signed pair, accumulates and reports one dot product
// with a done pulse. Optional saturation of the result: DOT_MAC_SAT_EN.
module dot_mac_engine
  import dot_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] a_di,
  input  logic [DATA_W-1:0] b_di,
  output logic              busy_o,
  output logic              done_o,
  output logic [RES_W-1:0]  res_o
);

  state_t                   state;
  logic [ADDR_W-1:0]        len_q;
  logic [ADDR_W-1:0]        cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [RES_W-1:0]  prod_q;
  logic                     pv;

  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  b_ext;
  logic signed [RES_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic        [RES_W-1:0]  fit_res;

  // The RAMs are read combinationally, so the address comes straight from the counter.
  assign addr_o = (state == RUN) ? cnt : '0;

  // Operands are sign-extended to the product width; the full product fits exactly.
  assign a_ext    = {{(RES_W-DATA_W){a_di[DATA_W-1]}}, a_di};
  assign b_ext    = {{(RES_W-DATA_W){b_di[DATA_W-1]}}, b_di};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-RES_W){prod_q[RES_W-1]}}, prod_q};
  assign sum      = acc + prod_ext;

  dot_mac_fit u_fit (
    .acc (sum),
    .res (fit_res)
  );

  // Control FSM with a one-stage product register feeding the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      prod_q <= '0;
      pv     <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      res_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              len_q  <= len_i;
              cnt    <= '0;
              acc    <= '0;
              pv     <= 1'b0;
              busy_o <= 1'b1;
              state  <= RUN;
            end else begin
              res_o  <= '0;
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          prod_q <= prod;
          pv     <= 1'b1;
          if (pv) begin
            acc <= sum;
          end
          cnt <= cnt + ADDR_W'(1);
          if (cnt == len_q - ADDR_W'(1)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          res_o  <= fit_res;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          pv     <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
